muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers for the MIPS-style processor datapath, parametrised in operand width. It runs beside the single-cycle ALU and executes MULT/MULTU/DIV/DIVU over WIDTH cycles using a start/busy/done handshake. Control stalls on `busy`, and MFHI/MFLO read `hi`/`lo` directly. MTHI/MTLO write HI/LO through dedicated write enables.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Minimum 4.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `start`  in  1: request a new operation. Sampled only while idle.
- `op`  in  2: operation select.
  - 00 = MULTU
  - 01 = MULT
  - 10 = DIVU
  - 11 = DIV
- `a`  in  WIDTH: rs operand (multiplicand / dividend). Sampled with `start`.
- `b`  in  WIDTH: rt operand (multiplier / divisor). Sampled with `start`.
- `wehi`  in  1: MTHI write enable.
- `welo`  in  1: MTLO write enable.
- `wdata`  in  WIDTH: MTHI/MTLO write data.
- `busy`  out  1: operation in progress. Control must stall dependent instructions.
- `done`  out  1: one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH: HI register. Holds the remainder for division.
- `lo`  out  WIDTH: LO register. Holds the quotient for division.

## Operation
- FSM has two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1. An internal counter, $clog2(WIDTH) bits, counts down from WIDTH-1.
- IDLE with `start`=1 goes to RUN. The edge latches `op`, the operand magnitudes and the result sign.
  - Signed ops (`op[0]`=1) take absolute values of `a` and `b`.
  - Product/quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Multiply uses shift-add into a 2·WIDTH accumulator, one multiplier bit per cycle.
- Divide is restoring, one quotient bit per cycle, using a WIDTH+1-bit trial subtraction.
- Every RUN cycle performs one iteration.
- RUN with counter = 0 performs the final iteration and the sign fix-up (two's-complement negate where required). On that edge it writes HI/LO, returns to IDLE and sets `done` for exactly one cycle.
- Multiply result: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
- Divide by zero (DIV or DIVU, `b`=0): LO = all ones, HI = `a` unchanged, no sign fix-up.
- DIV of most-negative by −1: LO = most-negative (0x80000000 for WIDTH=32), HI = 0. No trap.
- `start` while RUN is ignored. No queueing, and the operation in progress is unaffected.
- `wehi`/`welo` while RUN are ignored.
- `wehi`/`welo` in IDLE (including the `done` cycle) write HI/LO on the next edge.
- `wehi`/`welo` in the same cycle as an accepted `start`: the write is applied, and the operation result overwrites it later.
- Reset, including mid-operation: the next edge forces IDLE, `busy`=0, `done`=0, `hi`=`lo`=0, counter = 0. The pending operation is abandoned and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.
- `start` is accepted at edge k. Then:
  - `busy`=1 during cycles k..k+WIDTH−1, i.e. exactly WIDTH cycles.
  - `hi`/`lo` are updated at edge k+WIDTH.
  - In cycle k+WIDTH, `done`=1 and `busy`=0.
- Back-to-back: `start` held high in the `done` cycle is accepted at edge k+WIDTH+1.
- `hi`/`lo` are registered and change only on completion, MTHI/MTLO or reset. Mid-operation they hold their previous value.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro `MULDIV_DIV_EN`.
- Defined: divide datapath compiled in; all four ops behave as above.
- Undefined: no divider logic. `start` with `op[1]`=1 is ignored in IDLE: no `busy`, no `done`, HI/LO unchanged. Multiply ops are unaffected.

## Structure
- Package `muldiv_pkg`: op encodings `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`, and the state typedef `muldiv_state_t` {IDLE, RUN}.
- Sub-module `cond_negate` (parameter `WIDTH`; inputs `neg` and `x`; output `y = neg ? −x : x`). It is instantiated for operand abs and for result fix-up of both HI and LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `busy` for 32 cycles, then `done` pulses once.
- MULT −3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Handshake and reset:
  - Second `start` at cycle 5 of a MULTU is ignored; the result is unchanged.
  - `wehi`=1 with `wdata`=0x1234 during RUN -> HI unaffected.
  - Reset at cycle 10 of a DIV -> next cycle `busy`=0, `hi`=`lo`=0, and no `done` follows.
  - With `WIDTH`=8, MULTU 0xFF × 0xFF -> HI=0xFE, LO=0x01 after 8 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and state type for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic {IDLE, RUN} muldiv_state_t;

endpackage

// File: rtl/muldiv_cond_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers, one iteration per cycle over WIDTH cycles.
// The divide datapath is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wehi,
    input  logic             welo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH;

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] bop_q, bop_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic             a_sgn, b_sgn, accept;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_step, iter_acc, prod_fix;
    logic [WIDTH-1:0] hi_res, lo_res;

    assign a_sgn = op[0] & a[WIDTH-1];
    assign b_sgn = op[0] & b[WIDTH-1];

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (.neg(a_sgn), .x(a), .y(a_abs));
    cond_negate #(.WIDTH(WIDTH)) u_abs_b (.neg(b_sgn), .x(b), .y(b_abs));

    // acc holds {partial product, remaining multiplier bits}; shift right each step
    assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, bop_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    cond_negate #(.WIDTH(AW)) u_fix_prod (.neg(neg_q), .x(iter_acc), .y(prod_fix));

`ifdef MULDIV_DIV_EN
    logic             is_div_q, is_div_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [AW-1:0]    div_step;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign accept = (state_q == IDLE) & start;

    // acc holds {remainder, dividend bits still to shift in / quotient bits so far}
    assign div_shift = acc_q[AW-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, bop_q};
    assign div_step  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign iter_acc  = is_div_q ? div_step : mul_step;

    // Divide by zero naturally yields quotient all-ones and remainder |a|; only the remainder is re-signed.
    cond_negate #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_q & ~dz_q), .x(iter_acc[WIDTH-1:0]), .y(quo_fix));
    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (.neg(rneg_q), .x(iter_acc[AW-1:WIDTH]), .y(rem_fix));

    assign hi_res = is_div_q ? rem_fix : prod_fix[AW-1:WIDTH];
    assign lo_res = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
`else
    assign accept   = (state_q == IDLE) & start & ~op[1];
    assign iter_acc = mul_step;
    assign hi_res   = prod_fix[AW-1:WIDTH];
    assign lo_res   = prod_fix[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bop_d   = bop_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (wehi) hi_d = wdata;
                if (welo) lo_d = wdata;
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = CW'(WIDTH - 1);
                    acc_d   = {{WIDTH{1'b0}}, a_abs};
                    bop_d   = b_abs;
                    neg_d   = a_sgn ^ b_sgn;
`ifdef MULDIV_DIV_EN
                    is_div_d = op[1];
                    rneg_d   = a_sgn;
                    dz_d     = (b == '0);
`endif
                end
            end
            RUN: begin
                acc_d = iter_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    hi_d    = hi_res;
                    lo_d    = lo_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            bop_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bop_q   <= bop_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
